// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data requesters share one word-wide RAM.
// Round-robin grant, sub-word loads/stores via read-modify-write, error replies.
module mem_arbiter #(
    parameter logic [31:0] ADDR_LO = 32'h01000000,
    parameter logic [31:0] ADDR_HI = 32'h01100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, ERR} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_data_last;
    logic        r_is_data;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic        r_d_rvalid;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    logic        w_idle;
    logic        w_pick_data;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_misalign;
    logic        w_range;
    logic        w_bad;
    logic        w_word_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_resp;
    logic [31:0] w_resp_data;
    logic        w_resp_err;

    // Data wins a tie only when fetch was the most recent grant.
    assign w_idle      = (r_state == IDLE) && reset_n;
    assign w_pick_data = d_req && (!if_req || !r_data_last);
    assign if_gnt      = w_idle && if_req && !w_pick_data;
    assign d_gnt       = w_idle && w_pick_data;
    assign w_gnt       = if_gnt || d_gnt;

    assign w_addr       = w_pick_data ? d_addr : if_addr;
    assign w_size       = w_pick_data ? d_size : 2'b10;
    assign w_range      = (w_addr < ADDR_LO) || (w_addr >= ADDR_HI);
    assign w_bad        = w_misalign || w_range;
    assign w_word_store = w_pick_data && d_we && (d_size == 2'b10);

    always_comb begin
        w_misalign = 1'b0;
        case (w_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_addr[0];
            2'b10:   w_misalign = |w_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt) begin
                    if (w_bad)
                        w_next = ERR;
                    else if (!w_pick_data || !d_we)
                        w_next = READ;
                    else if (w_word_store)
                        w_next = WRITE;
                    else
                        w_next = RMW_READ;
                end
            end
            READ:     w_next = IDLE;
            RMW_READ: w_next = WRITE;
            WRITE:    w_next = IDLE;
            ERR:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = mem_data_out[7:0];
        case (r_lane)
            2'b01:   w_byte = mem_data_out[15:8];
            2'b10:   w_byte = mem_data_out[23:16];
            2'b11:   w_byte = mem_data_out[31:24];
            default: w_byte = mem_data_out[7:0];
        endcase
        w_half = r_lane[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        w_load = mem_data_out;
        if (r_size == 2'b00)
            w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        else if (r_size == 2'b01)
            w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_merge = mem_data_out;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'b01:   w_merge[15:8]  = r_wdata[7:0];
                2'b10:   w_merge[23:16] = r_wdata[7:0];
                2'b11:   w_merge[31:24] = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    assign w_resp      = (r_state == READ) || (r_state == WRITE) || (r_state == ERR);
    assign w_resp_data = (r_state == READ) ? w_load : 32'h0;
    assign w_resp_err  = (r_state == ERR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_last   <= 1'b1;
            r_is_data     <= 1'b0;
            r_uns         <= 1'b0;
            r_size        <= 2'b10;
            r_lane        <= 2'b00;
            r_wdata       <= 16'h0;
            r_mem_address <= ADDR_LO;
            r_mem_data_in <= 32'h0;
            r_if_rvalid   <= 1'b0;
            r_if_rdata    <= 32'h0;
            r_if_err      <= 1'b0;
            r_d_rvalid    <= 1'b0;
            r_d_rdata     <= 32'h0;
            r_d_err       <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            if (w_gnt) begin
                r_data_last <= w_pick_data;
                r_is_data   <= w_pick_data;
                r_lane      <= w_addr[1:0];
                r_size      <= w_size;
                r_uns       <= d_unsigned;
                r_wdata     <= d_wdata[15:0];
                if (!w_bad)
                    r_mem_address <= {w_addr[31:2], 2'b00};
                if (!w_bad && w_word_store)
                    r_mem_data_in <= d_wdata;
            end
            if (r_state == RMW_READ)
                r_mem_data_in <= w_merge;
            if (w_resp && r_is_data) begin
                r_d_rvalid <= 1'b1;
                r_d_rdata  <= w_resp_data;
                r_d_err    <= w_resp_err;
            end else if (w_resp) begin
                r_if_rvalid <= 1'b1;
                r_if_rdata  <= w_resp_data;
                r_if_err    <= w_resp_err;
            end
        end
    end

    assign if_rvalid      = r_if_rvalid;
    assign if_rdata       = r_if_rdata;
    assign if_err         = r_if_err;
    assign d_rvalid       = r_d_rvalid;
    assign d_rdata        = r_d_rdata;
    assign d_err          = r_d_err;
    assign mem_address    = r_mem_address;
    assign mem_data_in    = r_mem_data_in;
    assign mem_read_write = (r_state == WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_mem_arbiter;

    localparam logic [31:0] LO = 32'h01000000;
    localparam logic [31:0] HI = 32'h01100000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [1:0]  d_size = 2'b10;
    logic        d_unsigned = 1'b0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write;

    logic [31:0] tb_mem [256];
    logic [7:0]  ref_b [1024];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = 8'h0;
    logic [31:0] bd_val = 32'h0;
    logic        both_seen = 1'b0;
    int          wr_cycles = 0;
    int          errors = 0;
    int          checks = 0;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
    );

    always #5 clock = ~clock;

    assign mem_data_out = tb_mem[mem_address[9:2]];

    always @(posedge clock) begin
        if (bd_we)
            tb_mem[bd_idx] = bd_val;
        else if (mem_read_write)
            tb_mem[mem_address[9:2]] = mem_data_in;
    end

    always @(negedge clock) begin
        if (if_rvalid && d_rvalid)
            both_seen = 1'b1;
        if (mem_read_write)
            wr_cycles = wr_cycles + 1;
    end

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        int off;
        @(negedge clock);
        bd_idx = addr[9:2];
        bd_val = val;
        bd_we = 1'b1;
        @(posedge clock);
        #1 bd_we = 1'b0;
        off = int'({addr[31:2], 2'b00} - LO);
        for (int i = 0; i < 4; i++)
            ref_b[off + i] = val[8*i +: 8];
    endtask

    // One transaction through either port; lat counts posedges from the
    // grant edge to the edge at which rvalid is sampled (-1 if rvalid never arrives).
    task automatic access(input bit is_d, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        logic rv;
        @(negedge clock);
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata;
            d_size = size; d_unsigned = uns; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        #1;
        n = 0;
        while (!(is_d ? d_gnt : if_gnt) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        rd = 32'h0; er = 1'b0; lat = -1;
        if (is_d ? d_gnt : if_gnt) begin
            @(posedge clock);
            #1 d_req = 1'b0; if_req = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clock);
                rv = is_d ? d_rvalid : if_rvalid;
                rd = is_d ? d_rdata : if_rdata;
                er = is_d ? d_err : if_err;
                @(posedge clock);
                if (rv) begin
                    lat = k;
                    break;
                end
            end
        end else begin
            d_req = 1'b0; if_req = 1'b0;
        end
    endtask

    // Reference: byte-addressed memory, little-endian assembly.
    task automatic model(input bit is_d, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] rd, output logic er,
                         output int lat);
        int nb, off;
        logic [1:0] sz;
        logic [31:0] v;
        sz = is_d ? size : 2'd2;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || (addr % 32'(nb) != 0) || addr < LO || addr >= HI;
        rd = 32'h0;
        lat = 2;
        if (!er) begin
            off = int'(addr - LO);
            if (is_d && we) begin
                for (int i = 0; i < nb; i++)
                    ref_b[off + i] = wdata[8*i +: 8];
                if (nb < 4)
                    lat = 3;
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++)
                    v[8*i +: 8] = ref_b[off + i];
                if (is_d && !uns && nb < 4 && v[8*nb-1])
                    for (int i = nb; i < 4; i++)
                        v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endtask

    task automatic test_reset;
        if_req = 1'b1; d_req = 1'b1;
        #1;
        checks++;
        if ({if_gnt, d_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt got=%b exp=00", {if_gnt, d_gnt});
        end
        checks++;
        if (mem_address !== LO) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=%h", mem_address, LO);
        end
        checks++;
        if ({mem_data_in, mem_read_write} !== 33'h0) begin
            errors++;
            $display("FAIL reset_mem got=%h/%b exp=0/0", mem_data_in, mem_read_write);
        end
        checks++;
        if ({if_rvalid, if_err, d_rvalid, d_err, if_rdata, d_rdata} !== 68'h0) begin
            errors++;
            $display("FAIL reset_resp got=%b%b%b%b %h %h exp=0",
                     if_rvalid, if_err, d_rvalid, d_err, if_rdata, d_rdata);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_fetch;
        logic [31:0] rd;
        logic er;
        int lat;
        set_word(LO + 32'h4, 32'h00500093);
        access(1'b0, 1'b0, LO + 32'h4, 32'h0, 2'd2, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'h00500093 || er !== 1'b0) begin
            errors++;
            $display("FAIL fetch_data got=%h err=%b exp=00500093 err=0", rd, er);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL fetch_lat got=%0d exp=2", lat);
        end
    endtask

    task automatic test_load_ext;
        logic [31:0] rd;
        logic er;
        int lat;
        set_word(LO + 32'h10, 32'h80FF0000);
        access(1'b1, 1'b0, LO + 32'h13, 32'h0, 2'd0, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL lb_signed got=%h err=%b lat=%0d exp=ffffff80 0 2", rd, er, lat);
        end
        access(1'b1, 1'b0, LO + 32'h13, 32'h0, 2'd0, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL lb_unsigned got=%h exp=00000080", rd);
        end
        access(1'b1, 1'b0, LO + 32'h12, 32'h0, 2'd1, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF80FF) begin
            errors++;
            $display("FAIL lh_signed got=%h exp=ffff80ff", rd);
        end
    endtask

    task automatic test_store;
        logic [31:0] rd;
        logic er;
        int lat;
        set_word(LO + 32'h10, 32'h11223344);
        access(1'b1, 1'b1, LO + 32'h11, 32'hFFFFFFAB, 2'd0, 1'b0, rd, er, lat);
        ref_b[32'h11] = 8'hAB;
        checks++;
        if (lat != 3 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_resp got lat=%0d rd=%h err=%b exp 3 0 0", lat, rd, er);
        end
        checks++;
        if (tb_mem[4] !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_mem got=%h exp=1122ab44", tb_mem[4]);
        end
        access(1'b1, 1'b1, LO + 32'h12, 32'h0000BEEF, 2'd1, 1'b0, rd, er, lat);
        ref_b[32'h12] = 8'hEF; ref_b[32'h13] = 8'hBE;
        checks++;
        if (tb_mem[4] !== 32'hBEEFAB44 || lat != 3) begin
            errors++;
            $display("FAIL sh_mem got=%h lat=%0d exp=beefab44 3", tb_mem[4], lat);
        end
        access(1'b1, 1'b1, LO + 32'h14, 32'hDEADC0DE, 2'd2, 1'b0, rd, er, lat);
        model(1'b1, 1'b0, LO + 32'h14, 32'h0, 2'd2, 1'b0, rd, er, lat);
        checks++;
        if (tb_mem[5] !== 32'hDEADC0DE || lat != 2) begin
            errors++;
            $display("FAIL sw_mem got=%h lat=%0d exp=deadc0de 2", tb_mem[5], lat);
        end
        for (int i = 0; i < 4; i++)
            ref_b[32'h14 + i] = tb_mem[5][8*i +: 8];
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic er;
        int lat, w0;
        w0 = wr_cycles;
        access(1'b1, 1'b0, LO + 32'h2, 32'h0, 2'd2, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin
            errors++;
            $display("FAIL err_misalign got err=%b rd=%h lat=%0d exp 1 0 2", er, rd, lat);
        end
        access(1'b1, 1'b1, HI, 32'h55, 2'd0, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_range got err=%b rd=%h exp 1 0", er, rd);
        end
        access(1'b1, 1'b1, LO + 32'h8, 32'h55, 2'd3, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL err_size got err=%b exp 1", er);
        end
        access(1'b0, 1'b0, LO + 32'h6, 32'h0, 2'd2, 1'b0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_fetch got err=%b rd=%h exp 1 0", er, rd);
        end
        checks++;
        if (wr_cycles != w0) begin
            errors++;
            $display("FAIL err_nowrite got=%0d write cycles exp=0", wr_cycles - w0);
        end
    endtask

    task automatic test_round_robin;
        bit order[$];
        int n;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        if_addr = LO; d_we = 1'b0; d_addr = LO + 32'h8;
        d_size = 2'd2; d_unsigned = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        n = 0;
        while (order.size() < 8 && n < 60) begin
            #1;
            if (if_gnt && d_gnt) begin
                checks++; errors++;
                $display("FAIL rr_double_gnt got=11 exp=one-hot");
            end
            if (if_gnt)
                order.push_back(1'b0);
            else if (d_gnt)
                order.push_back(1'b1);
            @(negedge clock);
            n++;
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (order.size() != 8) begin
            errors++;
            $display("FAIL rr_count got=%0d exp=8", order.size());
        end
        foreach (order[i]) begin
            checks++;
            if (order[i] !== 1'(i % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, addr, wd;
        logic er, eer, we, uns;
        logic [1:0] sz;
        int lat, elat, r;
        bit is_d;
        for (int it = 0; it < 80; it++) begin
            is_d = ($urandom % 3) != 0;
            we = $urandom % 2;
            uns = $urandom % 2;
            wd = $urandom;
            r = $urandom % 8;
            sz = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            r = $urandom % 16;
            if (r == 0)
                addr = HI + ($urandom % 64);
            else if (r == 1)
                addr = LO - 1 - ($urandom % 64);
            else begin
                addr = LO + ($urandom % 1024);
                if (r > 4 && (!is_d || sz == 2'd2))
                    addr[1:0] = 2'b00;
                else if (r > 4 && sz == 2'd1)
                    addr[0] = 1'b0;
            end
            access(is_d, we, addr, wd, sz, uns, rd, er, lat);
            model(is_d, we, addr, wd, sz, uns, erd, eer, elat);
            checks++;
            if (rd !== erd || er !== eer || lat != elat) begin
                errors++;
                $display("FAIL rand%0d d=%0d we=%b a=%h sz=%0d got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
                         it, is_d, we, addr, sz, rd, er, lat, erd, eer, elat);
            end
        end
        checks++;
        if (both_seen) begin
            errors++;
            $display("FAIL rvalid_overlap got=1 exp=0");
        end
    endtask

    task automatic test_reset_midwrite;
        int rv;
        set_word(LO + 32'h20, 32'hCAFEF00D);
        @(negedge clock);
        d_we = 1'b1; d_addr = LO + 32'h20; d_wdata = 32'h12345678;
        d_size = 2'd2; d_req = 1'b1;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt got=%b exp=1", d_gnt);
        end
        @(posedge clock);
        #1 d_req = 1'b0;
        checks++;
        if (mem_read_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_write got=%b exp=1", mem_read_write);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_read_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort got=%b exp=0", mem_read_write);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        rv = 0;
        repeat (6) begin
            @(negedge clock);
            if (d_rvalid)
                rv++;
        end
        checks++;
        if (rv != 0) begin
            errors++;
            $display("FAIL mid_rvalid got=%0d pulses exp=0", rv);
        end
        checks++;
        if (tb_mem[8] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL mid_mem got=%h exp=cafef00d", tb_mem[8]);
        end
    endtask

    task automatic test_mem_image;
        logic [31:0] w;
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            if (tb_mem[i] !== w) begin
                bad++;
                if (bad <= 4)
                    $display("FAIL mem_image[%0d] got=%h exp=%h", i, tb_mem[i], w);
            end
        end
        checks++;
        if (bad != 0)
            errors++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            set_word(LO + 32'(4 * i), $urandom);
        test_reset();
        test_fetch();
        test_load_ext();
        test_store();
        test_errors();
        test_round_robin();
        test_random();
        test_reset_midwrite();
        test_mem_image();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_LO, default 32'h01000000, lowest valid byte address of main memory.
REQ-002 Parameter ADDR_HI, default 32'h01100000, first byte address above main memory (exclusive).
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch requester wants a word read.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted at this posedge.
REQ-008 if_rvalid  output  1  one-cycle pulse: if_rdata/if_err valid.
REQ-009 if_rdata  output  32  fetched word.
REQ-010 if_err  output  1  fetch was misaligned or out of range.
REQ-011 d_req  input  1  data requester wants an access.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  32  data byte address.
REQ-014 d_wdata  input  32  store data, right-justified.
REQ-015 d_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-016 d_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-017 d_gnt  output  1  data request accepted at this posedge.
REQ-018 d_rvalid  output  1  one-cycle pulse: load data or store completion.
REQ-019 d_rdata  output  32  extended load result; 0 for stores.
REQ-020 d_err  output  1  data access misaligned, illegal size or out of range.
REQ-021 mem_address  output  32  word-aligned address to main memory.
REQ-022 mem_data_in  output  32  write data to main memory.
REQ-023 mem_data_out  input  32  combinational read data from main memory.
REQ-024 mem_read_write  output  1  0 read, 1 write (memory writes on posedge).

Function
REQ-025 FSM states IDLE, READ, RMW_READ, WRITE, ERR; only IDLE accepts requests.
REQ-026 IDLE, one requester active: its gnt asserts combinationally; request fields captured at that posedge.
REQ-027 IDLE, both active: round-robin -- grant the one not granted most recently; after reset fetch wins first.
REQ-028 gnt is never asserted outside IDLE; requester holds req and fields stable until gnt sampled high.
REQ-029 Error check at grant: fetch addr[1:0]!=0; half addr[0]!=0; word addr[1:0]!=0; d_size=11; addr<ADDR_LO or addr>=ADDR_HI -> ERR.
REQ-030 ERR: one cycle, no memory write; next cycle rvalid=1, err=1, rdata=0; FSM back in IDLE.
REQ-031 Load/fetch: IDLE->READ; READ drives mem_address={addr[31:2],2'b00}, mem_read_write=0; mem_data_out registered at end of READ.
REQ-032 Cycle after READ: rvalid=1, err=0, rdata valid, FSM IDLE (may grant same cycle); latency grant-edge to rvalid = 2 cycles.
REQ-033 Load extraction: byte lane addr[1:0], half lane addr[1]; extend per d_unsigned; word passes unchanged.
REQ-034 Word store: IDLE->WRITE; WRITE drives mem_read_write=1, mem_data_in=d_wdata for exactly one cycle; next cycle d_rvalid=1, d_rdata=0.
REQ-035 Byte/half store: IDLE->RMW_READ (read, capture word) ->WRITE with only the addressed lane(s) replaced by d_wdata low bits; other bytes preserved.
REQ-036 mem_read_write=1 only in WRITE; all other states 0.
REQ-037 mem_address holds last captured aligned address outside active states.
REQ-038 if_* and d_* response outputs never pulse simultaneously; rvalid only for the requester granted.

Reset
REQ-039 reset_n low: FSM IDLE, round-robin pointer = data-last, mem_read_write=0, mem_address=ADDR_LO, mem_data_in=0, all gnt/rvalid/err=0, rdata=0, immediately (asynchronous).
REQ-040 Reset mid-operation aborts the access: no write issued, no rvalid pulse after release.
REQ-041 First posedge after reset_n rises may grant.

Verification
REQ-042 Fetch if_addr=0x01000004, mem word 0x00500093 -> if_gnt, 2 cycles later if_rvalid=1, if_rdata=0x00500093, if_err=0.
REQ-043 Both req every cycle -> grants alternate fetch, data, fetch, data; no simultaneous rvalid.
REQ-044 Store byte 0xAB at 0x01000011 over word 0x11223344 -> memory word 0x1122AB44, d_rvalid 3 cycles after grant.
REQ-045 Load byte 0x01000013 from 0x80FF0000, d_unsigned=0 -> d_rdata=0xFFFFFF80; d_unsigned=1 -> 0x00000080.
REQ-046 d_addr=0x01000002 word, and d_addr=0x01100000 byte -> d_err=1, d_rdata=0, mem_read_write stays 0.
REQ-047 reset_n low during WRITE of word store -> mem_read_write drops to 0 at once, memory unchanged, no d_rvalid after release.
